// File: rtl/cpu_pkg.sv
// Shared CPU-pipeline definitions: load/store size codes, mem-stage FSM encoding, register index width.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int RW = 5;   // register-index width
    localparam int DW = 32;  // datapath width

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_MEM  = 1'b1
    } ms_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_e;

    // Stores only define SB/SH/SW; the unsigned codes are loads only, so for a
    // store they fall into "anything else is a word" like every other unused code.
    function automatic acc_size_e f3_size(input logic is_store, input logic [2:0] f3);
        if (f3 == F3_B || (!is_store && f3 == F3_BU)) return SZ_B;
        if (f3 == F3_H || (!is_store && f3 == F3_HU)) return SZ_H;
        return SZ_W;
    endfunction

    function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_H:    return lo[0];
            SZ_W:    return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundles for the mem stage: execute handshake, data-memory req/ack port, writeback/retire port.
// Latency: n/a (wires only).
// Backpressure: ex_rdy flows from mem stage to execute; dmem_ack completes a held request.
interface ex_if;
    import cpu_pkg::*;
    logic          ex_vld;
    logic          ex_rdy;
    logic [31:0]   ex_result;
    logic [31:0]   ex_sdata;
    logic          ex_mrd;
    logic          ex_mwr;
    logic [2:0]    ex_funct3;
    logic [RW-1:0] ex_rd;
    logic          ex_we;
    logic          flush;

    modport master (output ex_vld, ex_result, ex_sdata, ex_mrd, ex_mwr, ex_funct3, ex_rd, ex_we, flush,
                    input  ex_rdy);
    modport slave  (input  ex_vld, ex_result, ex_sdata, ex_mrd, ex_mwr, ex_funct3, ex_rd, ex_we, flush,
                    output ex_rdy);
endinterface

interface dmem_if #(parameter int AW = 32);
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [3:0]    dmem_be;
    logic [31:0]   dmem_wdata;
    logic          dmem_ack;
    logic [31:0]   dmem_rdata;

    modport master (output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                    input  dmem_ack, dmem_rdata);
    modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                    output dmem_ack, dmem_rdata);
endinterface

interface wb_if;
    import cpu_pkg::*;
    logic          wb_vld;
    logic          wb_we;
    logic [RW-1:0] wb_rd;
    logic [31:0]   wb_data;
    logic          misalign;
    logic [31:0]   misalign_addr;

    modport master (output wb_vld, wb_we, wb_rd, wb_data, misalign, misalign_addr);
    modport slave  (input  wb_vld, wb_we, wb_rd, wb_data, misalign, misalign_addr);
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load lane extract + extension.
// Latency: combinational.
// Backpressure: none.
// Ports: st_lo_i/st_funct3_i/sdata_i -> be_o/wdata_o ; ld_lane_i/ld_funct3_i/rdata_i -> ldata_o.
module lsu_align
    import cpu_pkg::*;
(
    input  logic [1:0]  st_lo_i,
    input  logic [2:0]  st_funct3_i,
    input  logic [31:0] sdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  ld_lane_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ldata_o
);

    acc_size_e   st_size;
    acc_size_e   ld_size;
    logic        ld_signed;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Sub-word data is replicated across the word so memory can pick any lane by be.
    always_comb begin
        st_size = f3_size(1'b1, st_funct3_i);
        be_o    = 4'b1111;
        wdata_o = sdata_i;
        case (st_size)
            SZ_B: begin
                be_o    = 4'b0001 << st_lo_i;
                wdata_o = {4{sdata_i[7:0]}};
            end
            SZ_H: begin
                be_o    = 4'b0011 << st_lo_i;
                wdata_o = {2{sdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_size   = f3_size(1'b0, ld_funct3_i);
        ld_signed = (ld_funct3_i == F3_B) || (ld_funct3_i == F3_H);
        ld_byte   = rdata_i[{ld_lane_i, 3'b000} +: 8];
        ld_half   = rdata_i[{ld_lane_i[1], 4'b0000} +: 16];
        ldata_o   = rdata_i;
        case (ld_size)
            SZ_B:    ldata_o = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SZ_H:    ldata_o = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory/retire stage: ALU results retire directly, aligned loads/stores run one req/ack transaction.
// Latency: ALU/misaligned op retires 1 cycle after accept; memory op retires 1 cycle after dmem_ack.
// Backpressure: ex_rdy is low while a memory request is outstanding; flush drops/suppresses ops.
// Ports: clk, rst_n (async active-low); ex (ex_if.slave); dmem (dmem_if.master); wb (wb_if.master).
module mem_stage
    import cpu_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic clk,
    input  logic rst_n,
    ex_if.slave     ex,
    dmem_if.master  dmem,
    wb_if.master    wb
);

    ms_state_e     state_q, state_d;
    logic          kill_q, kill_d;       // flush seen while in MEM: retire must be dropped
    logic          is_load_q, is_load_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    lane_q, lane_d;
    logic [RW-1:0] rd_q, rd_d;
    logic          we_q, we_d;

    logic          dmem_req_q, dmem_req_d;
    logic          dmem_we_q, dmem_we_d;
    logic [AW-1:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]    dmem_be_q, dmem_be_d;
    logic [31:0]   dmem_wdata_q, dmem_wdata_d;

    logic          wb_vld_q, wb_vld_d;
    logic          wb_we_q, wb_we_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          misalign_q, misalign_d;
    logic [31:0]   misalign_addr_q, misalign_addr_d;

    logic          ex_rdy;
    logic          accept;
    logic          is_mem;
    logic          misal;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [31:0]   ld_data;

    assign ex_rdy = (state_q == MS_IDLE);
    assign accept = ex.ex_vld & ex_rdy & ~ex.flush;
    assign is_mem = ex.ex_mrd | ex.ex_mwr;
    assign misal  = is_misaligned(f3_size(ex.ex_mwr, ex.ex_funct3), ex.ex_result[1:0]);

    // Store path works on the op being accepted; load path on the captured op.
    lsu_align u_lsu_align (
        .st_lo_i     (ex.ex_result[1:0]),
        .st_funct3_i (ex.ex_funct3),
        .sdata_i     (ex.ex_sdata),
        .be_o        (st_be),
        .wdata_o     (st_wdata),
        .ld_lane_i   (lane_q),
        .ld_funct3_i (f3_q),
        .rdata_i     (dmem.dmem_rdata),
        .ldata_o     (ld_data)
    );

    always_comb begin
        state_d         = state_q;
        kill_d          = kill_q;
        is_load_d       = is_load_q;
        f3_d            = f3_q;
        lane_d          = lane_q;
        rd_d            = rd_q;
        we_d            = we_q;
        dmem_req_d      = dmem_req_q;
        dmem_we_d       = dmem_we_q;
        dmem_addr_d     = dmem_addr_q;
        dmem_be_d       = dmem_be_q;
        dmem_wdata_d    = dmem_wdata_q;
        wb_vld_d        = 1'b0;
        wb_we_d         = wb_we_q;
        wb_rd_d         = wb_rd_q;
        wb_data_d       = wb_data_q;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;

        case (state_q)
            MS_IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        wb_vld_d  = 1'b1;
                        wb_we_d   = ex.ex_we;
                        wb_rd_d   = ex.ex_rd;
                        wb_data_d = ex.ex_result;
                    end else if (misal) begin
                        wb_vld_d        = 1'b1;
                        wb_we_d         = 1'b0;
                        wb_rd_d         = ex.ex_rd;
                        wb_data_d       = '0;
                        misalign_d      = 1'b1;
                        misalign_addr_d = ex.ex_result;
                    end else begin
                        state_d      = MS_MEM;
                        kill_d       = 1'b0;
                        is_load_d    = ~ex.ex_mwr;
                        f3_d         = ex.ex_funct3;
                        lane_d       = ex.ex_result[1:0];
                        rd_d         = ex.ex_rd;
                        we_d         = ex.ex_we;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = ex.ex_mwr;
                        dmem_addr_d  = {ex.ex_result[AW-1:2], 2'b00};
                        // Loads fetch the whole word; the lane is picked on return.
                        dmem_be_d    = ex.ex_mwr ? st_be : 4'b1111;
                        dmem_wdata_d = ex.ex_mwr ? st_wdata : '0;
                    end
                end
            end
            MS_MEM: begin
                if (ex.flush) kill_d = 1'b1;
                if (dmem.dmem_ack) begin
                    state_d    = MS_IDLE;
                    dmem_req_d = 1'b0;
                    if (!kill_q && !ex.flush) begin
                        wb_vld_d  = 1'b1;
                        wb_rd_d   = rd_q;
                        wb_we_d   = is_load_q ? we_q : 1'b0;
                        wb_data_d = is_load_q ? ld_data : '0;
                    end
                end
            end
            default: state_d = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= MS_IDLE;
            kill_q          <= 1'b0;
            is_load_q       <= 1'b0;
            f3_q            <= '0;
            lane_q          <= '0;
            rd_q            <= '0;
            we_q            <= 1'b0;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= '0;
            dmem_be_q       <= '0;
            dmem_wdata_q    <= '0;
            wb_vld_q        <= 1'b0;
            wb_we_q         <= 1'b0;
            wb_rd_q         <= '0;
            wb_data_q       <= '0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            kill_q          <= kill_d;
            is_load_q       <= is_load_d;
            f3_q            <= f3_d;
            lane_q          <= lane_d;
            rd_q            <= rd_d;
            we_q            <= we_d;
            dmem_req_q      <= dmem_req_d;
            dmem_we_q       <= dmem_we_d;
            dmem_addr_q     <= dmem_addr_d;
            dmem_be_q       <= dmem_be_d;
            dmem_wdata_q    <= dmem_wdata_d;
            wb_vld_q        <= wb_vld_d;
            wb_we_q         <= wb_we_d;
            wb_rd_q         <= wb_rd_d;
            wb_data_q       <= wb_data_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign ex.ex_rdy          = ex_rdy;
    assign dmem.dmem_req      = dmem_req_q;
    assign dmem.dmem_we       = dmem_we_q;
    assign dmem.dmem_addr     = dmem_addr_q;
    assign dmem.dmem_be       = dmem_be_q;
    assign dmem.dmem_wdata    = dmem_wdata_q;
    assign wb.wb_vld          = wb_vld_q;
    assign wb.wb_we           = wb_we_q;
    assign wb.wb_rd           = wb_rd_q;
    assign wb.wb_data         = wb_data_q;
    assign wb.misalign        = misalign_q;
    assign wb.misalign_addr   = misalign_addr_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory/retire stage of the CPU pipeline, directly downstream of the execute-stage ALU. It consumes the ALU `result` as either a writeback value or a data-memory byte address. It runs load/store transactions on the data-memory req/ack port and delivers one retired instruction per accepted op to writeback. Stalls are applied to execute via a ready/valid handshake.

## Interface
- Parameters:
  - `AW`, default 32: data-memory byte-address width.
  - `DW`, fixed 32: data width.
- Ports:
  - `clk` in 1: clock, rising edge.
  - `rst_n` in 1: asynchronous active-low reset.
  - `ex_vld` in 1: execute presents an op.
  - `ex_rdy` out 1: stage can accept an op this cycle.
  - `ex_result` in 32: ALU result (value or address).
  - `ex_sdata` in 32: store data (rs2).
  - `ex_mrd` / `ex_mwr` in 1 each: load / store op; both 0 means ALU op.
  - `ex_funct3` in 3: size/sign code — LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
  - `ex_rd` in 5: destination register.
  - `ex_we` in 1: op writes `rd`.
  - `flush` in 1: kill ops not yet issued to memory.
  - `dmem_req` out 1: memory request.
  - `dmem_we` out 1: write request.
  - `dmem_addr` out AW: word-aligned address, `[1:0]`=0.
  - `dmem_be` out 4: byte enables.
  - `dmem_wdata` out 32: lane-shifted store data.
  - `dmem_ack` in 1: memory completes the request; `dmem_rdata` valid this cycle.
  - `dmem_rdata` in 32: read word.
  - `wb_vld` out 1: one-cycle retire pulse.
  - `wb_we` out 1: retire writes register.
  - `wb_rd` out 5: retire destination.
  - `wb_data` out 32: retire value.
  - `misalign` out 1: one-cycle pulse, misaligned access retired without memory access.
  - `misalign_addr` out 32: faulting address.

## Operation
- FSM states:
  - `IDLE`: `ex_rdy`=1.
  - `MEM`: request outstanding, `ex_rdy`=0.
- Accept condition: `ex_vld & ex_rdy & ~flush`. Ops presented while `flush`=1 are dropped.
- ALU op accepted: next cycle `wb_vld`=1, `wb_data`=`ex_result`, `wb_we`=`ex_we`, `wb_rd`=`ex_rd`. FSM stays `IDLE`. Throughput is 1 op/cycle.
- Misalignment: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Next cycle: `wb_vld`=1, `wb_we`=0, `misalign`=1, `misalign_addr`=address.
  - No memory request. FSM stays `IDLE`.
- Aligned load/store accepted: address, data and control are captured; FSM goes to `MEM`.
- In `MEM`:
  - `dmem_req`=1 and all `dmem_*` outputs stay stable until `dmem_ack`.
  - On `dmem_ack`: FSM returns to `IDLE`.
  - Next cycle `wb_vld`=1. Loads: `wb_we`=captured `ex_we`, `wb_data`=extended lane. Stores: `wb_we`=0, `wb_data`=0.
- Store lanes:
  - SB: `be`=`0001<<addr[1:0]`, data byte replicated ×4.
  - SH: `be`=`0011<<addr[1:0]`, half replicated ×2.
  - SW: `be`=`1111`.
- Load extraction:
  - Lane selected by `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- `flush` in `MEM`: the bus transaction still completes (`dmem_req` is held to `ack`), but the retire is suppressed (`wb_vld`=0). `flush` on the same cycle as `dmem_ack` also suppresses the retire.
- Unused `ex_funct3` codes are treated as LW/SW.

## Timing
- Reset values:
  - State `IDLE`; `ex_rdy`=1.
  - `dmem_req`, `dmem_we`, `wb_vld`, `wb_we`, `misalign` = 0.
  - `dmem_addr`, `dmem_be`, `dmem_wdata`, `wb_rd`, `wb_data`, `misalign_addr` = 0.
- Latency:
  - ALU op: accepted cycle T, retired T+1.
  - Memory op: accepted T; `dmem_req` rises T+1. If ack arrives at T+k (k≥1), the retire is at T+k+1 and `ex_rdy`=1 again at T+k+1.
- Back-to-back: an op may be accepted in the same cycle a previous one retires.
- All outputs are registered except `ex_rdy`, which is decoded from state.
- Reset asserted mid-transaction: FSM goes to `IDLE` immediately and `dmem_req` drops. The memory side must tolerate an abandoned request.

## Structure
- The shared package `cpu_pkg` holds:
  - `funct3` load/store codes (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the FSM state encoding (`MS_IDLE`, `MS_MEM`);
  - register-index width 5.
- One combinational sub-module, `lsu_align`:
  - store path: `addr[1:0]`, `funct3`, `sdata` → `be`, `wdata`;
  - load path: `addr[1:0]`, `funct3`, `rdata` → extended load data.
- Estimated size: `mem_stage` ~200 lines, `lsu_align` ~80 lines.

## Test plan
- ALU ops back-to-back: `ex_result` 0x11, then 0x22, with `ex_rd` 3 and 4 → `wb_vld` on two consecutive cycles with 0x11/rd3 then 0x22/rd4; `dmem_req` never rises.
- LB at 0x103, with rdata 0x80FF_FF00 returned after a 3-cycle ack delay → `be` ignored, `dmem_addr`=0x100, `wb_data`=0xFFFF_FF80; `ex_rdy` low for 3 cycles.
- SH at 0x202, sdata 0x1234_ABCD → `dmem_we`=1, `be`=1100, `wdata`=0xABCD_ABCD, `wb_we`=0 on retire.
- LW at 0x301 → `misalign`=1, `misalign_addr`=0x301, no `dmem_req`, `wb_we`=0.
- LHU at 0x400 with `flush` asserted while in `MEM` → request held until ack, no `wb_vld`; the next ALU op retires normally.
- `rst_n` dropped while `dmem_req`=1 → all outputs 0 asynchronously, `ex_rdy`=1 after release.
